// File: rtl/video_line_fifo_if.sv
// video_line_fifo_if: bus between the fetch/pixel stages and video_line_fifo.
//   master : data, load, en, clear_err out; status and pixel stream in
//   slave  : the FIFO side (inverse directions)
//   data/load/ready  word write handshake
//   en/video/video_valid  pixel request and registered pixel stream
//   level/empty/full/watermark_on  fill status
//   overflow/underflow/clear_err  sticky error flags and their clear
interface video_line_fifo_if #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned SLICES  = 4,
    parameter int unsigned DEPTH   = 4
);
    localparam int unsigned WORD_W = SLICES * PIXEL_W;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    logic [WORD_W-1:0]  data;
    logic               load;
    logic               ready;
    logic               en;
    logic [PIXEL_W-1:0] video;
    logic               video_valid;
    logic [LVL_W-1:0]   level;
    logic               empty;
    logic               full;
    logic               watermark_on;
    logic               overflow;
    logic               underflow;
    logic               clear_err;

    modport master (
        output data, load, en, clear_err,
        input  ready, video, video_valid, level, empty, full,
               watermark_on, overflow, underflow
    );

    modport slave (
        input  data, load, en, clear_err,
        output ready, video, video_valid, level, empty, full,
               watermark_on, overflow, underflow
    );
endinterface

// File: rtl/video_line_fifo.sv
// video_line_fifo: circular store of DEPTH words of SLICES pixels each,
// drained one pixel per enabled clock, least-significant slice first.
//   clk25MHz  pixel clock
//   reset_n   asynchronous active-low reset
//   bus       video_line_fifo_if.slave (write port, pixel port, status, errors)
module video_line_fifo #(
    parameter int unsigned PIXEL_W   = 8,
    parameter int unsigned SLICES    = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WATERMARK = 1
) (
    input  logic                clk25MHz,
    input  logic                reset_n,
    video_line_fifo_if.slave    bus
);
    localparam int unsigned WORD_W = SLICES * PIXEL_W;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLC_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [SLC_W-1:0]   slice_idx;
    logic [LVL_W-1:0]   level_q;
    logic [PIXEL_W-1:0] video_q;
    logic               video_valid_q;
    logic               overflow_q;
    logic               underflow_q;

    logic               empty_c;
    logic               full_c;
    logic               wr_acc_c;
    logic               rd_acc_c;
    logic               rd_done_c;
    logic [PIXEL_W-1:0] pixel_c;
    logic [LVL_W-1:0]   level_nxt_c;

    // Status derived from the registered level only.
    assign empty_c   = (level_q == '0);
    assign full_c    = (level_q == LVL_W'(DEPTH));
    assign wr_acc_c  = bus.load && !full_c;
    assign rd_acc_c  = bus.en && !empty_c;
    assign rd_done_c = rd_acc_c && (slice_idx == SLC_W'(SLICES - 1));

    // Current slice of the head word.
    always_comb begin
        pixel_c = PIXEL_W'(mem[rd_ptr] >> (int'(slice_idx) * int'(PIXEL_W)));
    end

    // Level bookkeeping; a write and a word-completing read cancel out.
    always_comb begin
        level_nxt_c = level_q;
        if (wr_acc_c && !rd_done_c) begin
            level_nxt_c = level_q + LVL_W'(1);
        end else if (!wr_acc_c && rd_done_c) begin
            level_nxt_c = level_q - LVL_W'(1);
        end
    end

    // Word storage; contents are don't-care after reset.
    always_ff @(posedge clk25MHz) begin
        if (wr_acc_c) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    // Pointers, slice index and level.
    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            slice_idx <= '0;
            level_q   <= '0;
        end else begin
            level_q <= level_nxt_c;
            if (wr_acc_c) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_done_c) begin
                slice_idx <= '0;
                rd_ptr    <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end else if (rd_acc_c) begin
                slice_idx <= slice_idx + SLC_W'(1);
            end
        end
    end

    // Pixel output: new pixel on a served request, blank on underflow, hold otherwise.
    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            video_q       <= '0;
            video_valid_q <= 1'b0;
        end else begin
            video_valid_q <= rd_acc_c;
            if (rd_acc_c) begin
                video_q <= pixel_c;
            end else if (bus.en) begin
                video_q <= '0;
            end
        end
    end

    // Sticky error flags; a new error wins over clear_err.
    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.load && full_c) begin
                overflow_q <= 1'b1;
            end else if (bus.clear_err) begin
                overflow_q <= 1'b0;
            end
            if (bus.en && empty_c) begin
                underflow_q <= 1'b1;
            end else if (bus.clear_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.ready        = !full_c;
    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.watermark_on = (level_q <= LVL_W'(WATERMARK));
    assign bus.level        = level_q;
    assign bus.video        = video_q;
    assign bus.video_valid  = video_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_video_line_fifo.sv
// tb_video_line_fifo: table-driven vectors plus hand sequences, checked
// against a queue-based reference model and a pixel scoreboard.
module tb_video_line_fifo;
    localparam int unsigned PIXEL_W   = 8;
    localparam int unsigned SLICES    = 4;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned WATERMARK = 1;

    logic clk = 1'b0;
    logic reset_n;

    video_line_fifo_if #(.PIXEL_W(PIXEL_W), .SLICES(SLICES), .DEPTH(DEPTH)) bus ();

    video_line_fifo #(
        .PIXEL_W(PIXEL_W), .SLICES(SLICES), .DEPTH(DEPTH), .WATERMARK(WATERMARK)
    ) dut (
        .clk25MHz (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [7:0]  sb[$];
    int          ms;
    logic [7:0]  m_video;
    bit          m_valid;
    bit          m_ovf;
    bit          m_unf;

    typedef struct {
        bit          ld;
        logic [31:0] d;
        bit          en;
        bit          clr;
        logic [7:0]  v;
        bit          vv;
        int          lvl;
        bit          emp;
        bit          unf;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        ms      = 0;
        m_video = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic compare_all();
        logic [7:0] exp_pix;
        if (bus.video_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_pixel: got %0h, expected no pixel", bus.video);
            end else begin
                exp_pix = sb.pop_front();
                check("sb_pixel", 32'(bus.video), 32'(exp_pix));
            end
        end else if (m_valid && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        check("video_valid", 32'(bus.video_valid), 32'(m_valid));
        check("video", 32'(bus.video), 32'(m_video));
        check("level", 32'(bus.level), 32'(mq.size()));
        check("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        check("ready", 32'(bus.ready), 32'(mq.size() != DEPTH));
        check("watermark_on", 32'(bus.watermark_on), 32'(mq.size() <= WATERMARK));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    // Drive one clock of stimulus, advance the model on pre-edge state, compare after the edge.
    task automatic cycle(input bit ld, input logic [31:0] d, input bit e, input bit clr);
        bit          mfull;
        bit          memp;
        logic [31:0] w;
        bus.load      = ld;
        bus.data      = d;
        bus.en        = e;
        bus.clear_err = clr;
        mfull = (mq.size() == DEPTH);
        memp  = (mq.size() == 0);
        m_ovf   = (ld && mfull) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf   = (e && memp) ? 1'b1 : (clr ? 1'b0 : m_unf);
        m_valid = 1'b0;
        if (e && memp) begin
            m_video = '0;
        end else if (e) begin
            w       = mq[0];
            m_video = w[ms*PIXEL_W +: PIXEL_W];
            m_valid = 1'b1;
            sb.push_back(m_video);
            if (ms == SLICES - 1) begin
                ms = 0;
                void'(mq.pop_front());
            end else begin
                ms++;
            end
        end
        if (ld && !mfull) mq.push_back(d);
        @(posedge clk);
        #1;
        compare_all();
        bus.load      = 1'b0;
        bus.en        = 1'b0;
        bus.clear_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_video"}, 32'(bus.video), 32'h0);
        check({tag, "_valid"}, 32'(bus.video_valid), 32'h0);
        check({tag, "_level"}, 32'(bus.level), 32'h0);
        check({tag, "_empty"}, 32'(bus.empty), 32'h1);
        check({tag, "_full"}, 32'(bus.full), 32'h0);
        check({tag, "_ready"}, 32'(bus.ready), 32'h1);
        check({tag, "_wm"}, 32'(bus.watermark_on), 32'h1);
        check({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
        check({tag, "_unf"}, 32'(bus.underflow), 32'h0);
    endtask

    initial begin
        int          sent;
        int          exp_pix;
        int          guard;
        bit          ld;
        logic [31:0] wd;

        reset_n       = 1'b0;
        bus.load      = 1'b0;
        bus.data      = '0;
        bus.en        = 1'b0;
        bus.clear_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        compare_all();
        reset_n = 1'b1;

        // Single word drain, then underflow / clear_err behaviour
        tv[0] = '{1'b1, 32'h44332211, 1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0};
        tv[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h11, 1'b1, 1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h22, 1'b1, 1, 1'b0, 1'b0};
        tv[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h33, 1'b1, 1, 1'b0, 1'b0};
        tv[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h44, 1'b1, 0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b1};
        tv[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b0};
        tv[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b1};
        tv[8] = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cycle(tv[i].ld, tv[i].d, tv[i].en, tv[i].clr);
            check($sformatf("tv%0d_video", i), 32'(bus.video), 32'(tv[i].v));
            check($sformatf("tv%0d_valid", i), 32'(bus.video_valid), 32'(tv[i].vv));
            check($sformatf("tv%0d_level", i), 32'(bus.level), 32'(tv[i].lvl));
            check($sformatf("tv%0d_empty", i), 32'(bus.empty), 32'(tv[i].emp));
            check($sformatf("tv%0d_unf", i), 32'(bus.underflow), 32'(tv[i].unf));
        end

        // Fill to full, overflow on a 5th load, content unchanged on readback
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA0A0A0A0 + 32'(i * 32'h01010101), 1'b0, 1'b0);
        check("fill_full", 32'(bus.full), 32'h1);
        check("fill_ready", 32'(bus.ready), 32'h0);
        check("fill_level", 32'(bus.level), 32'h4);
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        check("ovf_set", 32'(bus.overflow), 32'h1);
        check("ovf_level", 32'(bus.level), 32'h4);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            check("readback", 32'(bus.video), 32'(8'hA0 + 8'(i / 4)));
        end

        // Load on the word-completing read: rejected when full, balanced at level 2
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10203040 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'hBADBAD00, 1'b1, 1'b0);
        check("full_coinc_level", 32'(bus.level), 32'h3);
        check("full_coinc_ovf", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("pre_coinc_level", 32'(bus.level), 32'h2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'hCAFE0001, 1'b1, 1'b0);
        check("coinc_level", 32'(bus.level), 32'h2);
        check("coinc_ovf", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("coinc_tail", 32'(bus.video), 32'h0000_00CA);

        // Streaming: continuous en, refill whenever the watermark is on
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h03020100, 1'b0, 1'b0);
        sent    = 1;
        exp_pix = 0;
        guard   = 0;
        while (mq.size() > 0 && guard < 200) begin
            ld = (sent < 12) && (mq.size() <= WATERMARK);
            wd = {8'(4*sent + 3), 8'(4*sent + 2), 8'(4*sent + 1), 8'(4*sent)};
            cycle(ld, wd, 1'b1, 1'b0);
            if (ld) sent++;
            check("stream_valid", 32'(bus.video_valid), 32'h1);
            check("stream_seq", 32'(bus.video), 32'(exp_pix));
            exp_pix++;
            guard++;
        end
        check("stream_count", 32'(exp_pix), 32'd48);
        check("stream_unf", 32'(bus.underflow), 32'h0);

        // Asynchronous reset mid-word
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5A5B5C5D + 32'(i), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("pre_rst_level", 32'(bus.level), 32'h3);
        check("pre_rst_unf", 32'(bus.underflow), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        reset_n = 1'b1;
        cycle(1'b1, 32'h77665544, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("post_rst_pixel", 32'(bus.video), 32'h44);
        check("post_rst_valid", 32'(bus.video_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
